// File: rtl/tilemap_scheduler.sv
// Frame walker for the tile drawer: reads a row-major tile map and issues one draw
// job per non-empty entry, waiting for the drawer's end-of-tile strobe between jobs.
module tilemap_scheduler #(
    parameter int          MAP_W     = 20,
    parameter int          MAP_H     = 15,
    parameter int          MAP_AW    = 12,
    parameter logic [7:0]  SKIP_CODE = 8'hFF,
    parameter int          TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [MAP_AW-1:0] map_base,
    output logic [MAP_AW-1:0] map_addr,
    input  logic [7:0]        map_data,
    output logic [7:0]        tile_address,
    output logic [7:0]        x_pos,
    output logic [7:0]        y_pos,
    output logic              draw,
    input  logic              drawer_active,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [11:0]       tiles_drawn
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [4:0]        COL_LAST  = 5'(MAP_W - 1);
    localparam logic [4:0]        ROW_LAST  = 5'(MAP_H - 1);
    localparam logic [WCW-1:0]    WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [MAP_AW-1:0] IDX_ONE   = MAP_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_MAP, S_ISSUE, S_WAIT_DONE, S_ADVANCE, S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [MAP_AW-1:0] base_q, base_d;
    logic [MAP_AW-1:0] idx_q, idx_d;
    logic [MAP_AW-1:0] map_addr_q, map_addr_d;
    logic [4:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [7:0]        tile_q, tile_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic              draw_q, draw_d;
    logic              done_q, done_d;
    logic              terr_q, terr_d;
    logic [11:0]       tiles_q, tiles_d;
    logic [WCW-1:0]    wait_q, wait_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            map_addr_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            tile_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            draw_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            tiles_q    <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            map_addr_q <= map_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            tile_q     <= tile_d;
            x_q        <= x_d;
            y_q        <= y_d;
            draw_q     <= draw_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
            tiles_q    <= tiles_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        map_addr_d = map_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        tile_d     = tile_q;
        x_d        = x_q;
        y_d        = y_q;
        terr_d     = terr_q;
        tiles_d    = tiles_q;
        wait_d     = wait_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_FETCH;
                    base_d  = map_base;
                    idx_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    tiles_d = '0;
                    terr_d  = 1'b0;
                end
            end
            S_FETCH: begin
                map_addr_d = base_q + idx_q;
                state_d    = S_WAIT_MAP;
            end
            S_WAIT_MAP: begin
                if (map_data == SKIP_CODE) begin
                    state_d = S_ADVANCE;
                end else begin
                    tile_d  = map_data;
                    x_d     = {col_q, 3'b000};
                    y_d     = {row_q, 3'b000};
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tiles_d = tiles_q + 12'd1;
                wait_d  = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // End-of-tile strobe takes priority over a timeout on the same cycle.
                if (!drawer_active) begin
                    state_d = S_ADVANCE;
                end else if (wait_q == WAIT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_ADVANCE: begin
                idx_d = idx_q + IDX_ONE;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 5'd1;
                end else begin
                    col_d = col_q + 5'd1;
                end
                state_d = (col_q == COL_LAST && row_q == ROW_LAST) ? S_FINISH : S_FETCH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end

        // Pulses are registered so they line up with the state they belong to.
        draw_d = (state_d == S_ISSUE);
        done_d = (state_d == S_FINISH);
    end

    assign map_addr     = map_addr_q;
    assign tile_address = tile_q;
    assign x_pos        = x_q;
    assign y_pos        = y_q;
    assign draw         = draw_q;
    assign done         = done_q;
    assign busy         = (state_q != S_IDLE);
    assign timeout_err  = terr_q;
    assign tiles_drawn  = tiles_q;

endmodule

// File: tb/tb_tilemap_scheduler.sv
// Directed bench for tilemap_scheduler on a 2x2 map: a draw scoreboard checks every
// issued job against the expected tile/origin, plus timeout, abort, reset and start-while-busy.
module tb_tilemap_scheduler;

    localparam int TMO      = 50;
    localparam int DRAW_LAT = 20;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] map_base = '0;
    logic [11:0] map_addr;
    logic [7:0]  map_data;
    logic [7:0]  tile_address, x_pos, y_pos;
    logic        draw, drawer_active, busy, done, timeout_err;
    logic [11:0] tiles_drawn;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:4095];
    logic       hang = 1'b0;
    int         dcnt = 0;

    typedef struct packed {
        logic [7:0] t;
        logic [7:0] x;
        logic [7:0] y;
    } exp_t;
    exp_t exp_q[$];

    int   draws_seen = 0;
    int   dones_seen = 0;
    logic draw_prev = 1'b0;

    tilemap_scheduler #(
        .MAP_W(2), .MAP_H(2), .MAP_AW(12), .SKIP_CODE(8'hFF), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .map_base(map_base), .map_addr(map_addr), .map_data(map_data),
        .tile_address(tile_address), .x_pos(x_pos), .y_pos(y_pos),
        .draw(draw), .drawer_active(drawer_active), .busy(busy), .done(done),
        .timeout_err(timeout_err), .tiles_drawn(tiles_drawn)
    );

    always #5 clk = ~clk;

    assign map_data = mem[map_addr];

    // Drawer model: active except for a single low cycle DRAW_LAT cycles after a draw.
    assign drawer_active = !(dcnt == 1 && !hang);
    always @(posedge clk) begin
        if (draw) dcnt <= DRAW_LAT;
        else if (dcnt != 0) dcnt <= dcnt - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (draw) begin
            draws_seen++;
            chk("draw_single_cycle", {31'b0, draw_prev}, 32'd0);
            chk("draw_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("draw tile=%02h x=%0d y=%0d (exp %02h,%0d,%0d)",
                         tile_address, x_pos, y_pos, e.t, e.x, e.y);
                chk("draw_tile", {24'b0, tile_address}, {24'b0, e.t});
                chk("draw_x", {24'b0, x_pos}, {24'b0, e.x});
                chk("draw_y", {24'b0, y_pos}, {24'b0, e.y});
            end
        end
        if (done) dones_seen++;
        draw_prev = draw;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] t, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        e.t = t; e.x = x; e.y = y;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [11:0] base);
        map_base = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_walk(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_walk_ends"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_draws(input string tag, input int target);
        int n = 0;
        while (draws_seen < target && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_draw_reached"}, {31'b0, draws_seen >= target}, 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_map_addr"}, {20'b0, map_addr}, 32'd0);
        chk({tag, "_tile"}, {24'b0, tile_address}, 32'd0);
        chk({tag, "_x"}, {24'b0, x_pos}, 32'd0);
        chk({tag, "_y"}, {24'b0, y_pos}, 32'd0);
        chk({tag, "_draw"}, {31'b0, draw}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_terr"}, {31'b0, timeout_err}, 32'd0);
        chk({tag, "_tiles"}, {20'b0, tiles_drawn}, 32'd0);
    endtask

    initial begin
        int d0, dr0, k;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h00; mem[12'h101] = 8'h03; mem[12'h102] = 8'h06; mem[12'h103] = 8'h09;
        mem[12'h200] = 8'h10; mem[12'h201] = 8'hFF; mem[12'h202] = 8'hFF; mem[12'h203] = 8'h20;
        mem[12'h300] = 8'h01; mem[12'h301] = 8'h02; mem[12'h302] = 8'h03; mem[12'h303] = 8'h04;

        #1 resetn = 1'b0;
        #2 check_zero("reset");
        tick();
        resetn = 1'b1;
        tick();

        // Full 2x2 walk
        push(8'h00, 8'd0, 8'd0); push(8'h03, 8'd8, 8'd0);
        push(8'h06, 8'd0, 8'd8); push(8'h09, 8'd8, 8'd8);
        d0 = dones_seen;
        pulse_start(12'h100);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        run_walk("t1");
        chk("t1_done_pulses", dones_seen - d0, 32'd1);
        chk("t1_tiles", {20'b0, tiles_drawn}, 32'd4);
        chk("t1_queue_empty", exp_q.size(), 32'd0);
        $display("walk1 tiles=%0d dones=%0d", tiles_drawn, dones_seen - d0);

        // Skip entries
        push(8'h10, 8'd0, 8'd0); push(8'h20, 8'd8, 8'd8);
        d0 = dones_seen;
        pulse_start(12'h200);
        run_walk("t2");
        chk("t2_done_pulses", dones_seen - d0, 32'd1);
        chk("t2_tiles", {20'b0, tiles_drawn}, 32'd2);
        chk("t2_queue_empty", exp_q.size(), 32'd0);
        $display("walk2 tiles=%0d dones=%0d", tiles_drawn, dones_seen - d0);

        // Drawer never finishes: timeout after TMO wait cycles
        hang = 1'b1;
        push(8'h01, 8'd0, 8'd0);
        d0 = dones_seen;
        dr0 = draws_seen;
        pulse_start(12'h300);
        k = 0;
        while (!draw && k < 20) begin tick(); k++; end
        chk("t3_draw_seen", {31'b0, draw}, 32'd1);
        k = 0;
        while (busy && k < 200) begin tick(); k++; end
        chk("t3_timeout_cycles", k, TMO + 1);
        chk("t3_terr", {31'b0, timeout_err}, 32'd1);
        chk("t3_no_done", dones_seen - d0, 32'd0);
        chk("t3_tiles", {20'b0, tiles_drawn}, 32'd1);
        hang = 1'b0;
        $display("timeout walk cycles=%0d terr=%0b", k, timeout_err);

        // Next start clears the sticky error
        push(8'h00, 8'd0, 8'd0); push(8'h03, 8'd8, 8'd0);
        push(8'h06, 8'd0, 8'd8); push(8'h09, 8'd8, 8'd8);
        d0 = dones_seen;
        pulse_start(12'h100);
        chk("t3b_terr_cleared", {31'b0, timeout_err}, 32'd0);
        run_walk("t3b");
        chk("t3b_done_pulses", dones_seen - d0, 32'd1);
        chk("t3b_tiles", {20'b0, tiles_drawn}, 32'd4);

        // Abort during WAIT_DONE of the second tile
        push(8'h00, 8'd0, 8'd0); push(8'h03, 8'd8, 8'd0);
        d0 = dones_seen;
        dr0 = draws_seen;
        pulse_start(12'h100);
        wait_draws("t4", dr0 + 2);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_busy_after_abort", {31'b0, busy}, 32'd0);
        repeat (60) tick();
        chk("t4_draws", draws_seen - dr0, 32'd2);
        chk("t4_no_done", dones_seen - d0, 32'd0);
        chk("t4_tiles", {20'b0, tiles_drawn}, 32'd2);
        chk("t4_queue_empty", exp_q.size(), 32'd0);
        $display("abort walk draws=%0d dones=%0d", draws_seen - dr0, dones_seen - d0);

        // Async reset during WAIT_MAP
        pulse_start(12'h200);
        tick();
        chk("t5_wait_map_addr", {20'b0, map_addr}, 32'h200);
        resetn = 1'b0;
        #1 check_zero("t5_async");
        tick();
        resetn = 1'b1;
        tick();
        push(8'h10, 8'd0, 8'd0); push(8'h20, 8'd8, 8'd8);
        d0 = dones_seen;
        pulse_start(12'h200);
        chk("t5_tiles_restart", {20'b0, tiles_drawn}, 32'd0);
        tick();
        chk("t5_restart_addr", {20'b0, map_addr}, 32'h200);
        run_walk("t5");
        chk("t5_done_pulses", dones_seen - d0, 32'd1);
        chk("t5_tiles", {20'b0, tiles_drawn}, 32'd2);

        // Start while busy with a different base is ignored
        push(8'h10, 8'd0, 8'd0); push(8'h20, 8'd8, 8'd8);
        d0 = dones_seen;
        dr0 = draws_seen;
        pulse_start(12'h200);
        wait_draws("t6", dr0 + 1);
        repeat (3) tick();
        map_base = 12'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_walk("t6");
        chk("t6_done_pulses", dones_seen - d0, 32'd1);
        chk("t6_tiles", {20'b0, tiles_drawn}, 32'd2);
        chk("t6_queue_empty", exp_q.size(), 32'd0);
        $display("busy-start walk tiles=%0d dones=%0d", tiles_drawn, dones_seen - d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
